gcd_job_sequencer: RTL and testbench
====================================

Name: gcd_job_sequencer

Overview:
- Upstream feeder for GCD_module.
- Accepts operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Issues one pair at a time to the GCD core via x/y/start, waits for done, and captures the core's out.
- Presents results in order on a valid/ready output with a single-entry result register.

Parameters:
W, 8, operand/result width (matches GCD_module 8-bit x/y/out)
DEPTH, 4, operand FIFO depth in pairs (power of two, >=2)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept (not full)
in_x  in  W  operand x
in_y  in  W  operand y
gcd_x  out  W  drives GCD_module x
gcd_y  out  W  drives GCD_module y
gcd_start  out  1  drives GCD_module start
gcd_out  in  W  from GCD_module out
gcd_done  in  1  from GCD_module done
res_valid  out  1  result held
res_ready  in  1  consumer accepts result
res_data  out  W  GCD result
busy  out  1  FIFO non-empty, or FSM not IDLE, or res_valid

Behaviour:
- Reset (reset=0, async): FIFO emptied; FSM=IDLE; gcd_start=0; gcd_x=gcd_y=0; res_valid=0; res_data=0; in_ready=1; busy=0.
- FIFO push: in_valid&&in_ready. Pop only by FSM in IDLE. Push while full is ignored; in_ready=0 when count==DEPTH.
- Simultaneous push and pop on a full FIFO: pop happens, push is refused (in_ready reflects registered full). Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty and res_valid==0, pop the head and register it into gcd_x/gcd_y -> ISSUE.
  - ISSUE: gcd_start=1 -> WAIT (next cycle).
  - WAIT: gcd_start held 1, gcd_x/gcd_y stable. On gcd_done==1 sampled, capture res_data<=gcd_out, res_valid<=1, gcd_start<=0 -> DRAIN.
  - DRAIN: gcd_start=0 for one cycle; wait until gcd_done==0 (core returned to idle) -> IDLE.
- Min latency: pop to gcd_start high = 1 cycle. Result valid the cycle after done is sampled.
- Result register: held until res_valid&&res_ready, then cleared. No new issue while res_valid=1; ordering is strictly FIFO.
- gcd_x/gcd_y change only in IDLE on pop; stable whenever gcd_start=1.
- Reset mid-operation: all state is dropped, queued pairs and held result are lost, gcd_start drops immediately (async).
- Operands pass through unmodified; width rule W for all data paths.

Optional Feature:
- Macro: GCD_ZERO_BYPASS_EN.
- Defined: in IDLE, a popped pair with x==0 or y==0 does not issue to the core. res_data<=(x==0 ? y : x) and res_valid=1 in the cycle after the pop; FSM stays in IDLE, with no gcd_start pulse.
- Undefined: every pair is issued to the core regardless of value.

Decomposition:
- Package gcd_pkg: GCD_W=8, FIFO depth default, FSM state typedef (IDLE, ISSUE, WAIT, DRAIN).
- Sub-module gcd_pair_fifo: synchronous 2W-wide FIFO with count/full/empty, same CLK/reset.

Test Plan:
- Push (10,5), res_ready=1 with a behavioural GCD model -> gcd_start rises 1 cycle after pop; res_data=5, res_valid for 1 cycle; busy returns to 0.
- Back-to-back push (12,18),(7,3),(40,64) -> results 6,1,8 in order; gcd_start low ≥1 cycle between jobs.
- res_ready=0, push 6 pairs -> 1st issued and held, next 4 fill FIFO; in_ready=0 after 5 accepted; 6th refused until res_ready pulses.
- Push during full with concurrent pop -> push refused, no FIFO corruption; count stays DEPTH-1+0 consistent.
- Drop reset low mid-WAIT -> gcd_start=0 same cycle; res_valid=0; FIFO empty; next push (9,6) gives 3.
- (0,9) with GCD_ZERO_BYPASS_EN -> res_data=9, no gcd_start pulse; without macro -> issued to core.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job sequencer and its pair FIFO.
// Optional feature macro used by the sequencer: GCD_ZERO_BYPASS_EN.
package gcd_pkg;

    localparam int GCD_W          = 8;
    localparam int GCD_FIFO_DEPTH = 4;
    localparam int GCD_PAIR_W     = 2 * GCD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } gcd_state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of operand pairs with occupancy count and full/empty flags.
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module gcd_pair_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    // Full is taken from the registered count, so a pop in the same cycle never frees a slot early.
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Feeds buffered operand pairs one at a time to a GCD core and returns results in order.
// Optional: define GCD_ZERO_BYPASS_EN to answer pairs containing a zero without using the core.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W,
    parameter int DEPTH = GCD_FIFO_DEPTH
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic [W-1:0] gcd_x,
    output logic [W-1:0] gcd_y,
    output logic         gcd_start,
    input  logic [W-1:0] gcd_out,
    input  logic         gcd_done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         busy
);

    gcd_state_t r_state;
    gcd_state_t w_next_state;

    logic [W-1:0]            r_gcd_x;
    logic [W-1:0]            r_gcd_y;
    logic                    r_res_valid;
    logic [W-1:0]            r_res_data;

    logic [2*W-1:0]          w_head;
    logic [W-1:0]            w_head_x;
    logic [W-1:0]            w_head_y;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [$clog2(DEPTH):0]  w_fifo_count;
    logic                    w_pop;
    logic                    w_bypass;
    logic [W-1:0]            w_bypass_data;

    gcd_pair_fifo #(
        .W     (2 * W),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .i_push  (in_valid),
        .i_data  ({in_x, in_y}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_head_x      = w_head[2*W-1:W];
    assign w_head_y      = w_head[W-1:0];
    assign w_bypass_data = (w_head_x == '0) ? w_head_y : w_head_x;

`ifdef GCD_ZERO_BYPASS_EN
    assign w_bypass = (w_head_x == '0) || (w_head_y == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Start is decoded from the registered state so that reset removes it without waiting for a clock.
    assign gcd_start = (r_state == ISSUE) || (r_state == WAIT);
    assign gcd_x     = r_gcd_x;
    assign gcd_y     = r_gcd_y;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign in_ready  = !w_fifo_full;
    assign busy      = (w_fifo_count != '0) || (r_state != IDLE) || r_res_valid;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A new job is only taken once the previous result has been consumed, which keeps ordering strict.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty && !r_res_valid) begin
                    w_pop = 1'b1;
                    if (!w_bypass) begin
                        w_next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (gcd_done) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!gcd_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_gcd_x     <= '0;
            r_gcd_y     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (w_pop && !w_bypass) begin
                r_gcd_x <= w_head_x;
                r_gcd_y <= w_head_y;
            end
            if (w_pop && w_bypass) begin
                r_res_data  <= w_bypass_data;
                r_res_valid <= 1'b1;
            end else if ((r_state == WAIT) && gcd_done) begin
                r_res_data  <= gcd_out;
                r_res_valid <= 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural GCD core and a result scoreboard.
// Honours GCD_ZERO_BYPASS_EN when the design is built with it.
module tb_gcd_job_sequencer;

   logic       clock;
   logic       resetN;
   logic       inValid;
   logic       inReady;
   logic [7:0] inX;
   logic [7:0] inY;
   logic [7:0] gcdX;
   logic [7:0] gcdY;
   logic       gcdStart;
   logic [7:0] gcdOut;
   logic       gcdDone;
   logic       resValid;
   logic       resReady;
   logic [7:0] resData;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int startRises = 0;

   logic [7:0]  expQ[$];
   logic [15:0] issueQ[$];

   gcd_job_sequencer dut (
      .CLK       (clock),
      .reset     (resetN),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_x      (inX),
      .in_y      (inY),
      .gcd_x     (gcdX),
      .gcd_y     (gcdY),
      .gcd_start (gcdStart),
      .gcd_out   (gcdOut),
      .gcd_done  (gcdDone),
      .res_valid (resValid),
      .res_ready (resReady),
      .res_data  (resData),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference GCD by Euclid's remainder method, independent of the core model below
   function automatic logic [7:0] refGcd(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x = a;
      logic [7:0] y = b;
      logic [7:0] t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Every comparison in the bench funnels through here so the counters stay honest
   function automatic void checkOutput(input string tag, input logic [31:0] observed,
                                       input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endfunction

   // Behavioural GCD core: latches on start, subtracts until equal, holds done until start drops
   logic       mBusy;
   logic [7:0] mA;
   logic [7:0] mB;
   always @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         mBusy   <= 1'b0;
         gcdDone <= 1'b0;
         gcdOut  <= 8'd0;
         mA      <= 8'd0;
         mB      <= 8'd0;
      end else if (!gcdStart) begin
         mBusy   <= 1'b0;
         gcdDone <= 1'b0;
      end else if (!mBusy && !gcdDone) begin
         mBusy <= 1'b1;
         mA    <= gcdX;
         mB    <= gcdY;
      end else if (mBusy) begin
         if (mA == 0) begin
            gcdOut <= mB; gcdDone <= 1'b1; mBusy <= 1'b0;
         end else if (mB == 0 || mA == mB) begin
            gcdOut <= mA; gcdDone <= 1'b1; mBusy <= 1'b0;
         end else if (mA > mB) begin
            mA <= mA - mB;
         end else begin
            mB <= mB - mA;
         end
      end
   end

   // Monitor: checks each issued pair against the issue queue and each consumed result against the scoreboard
   logic       prevStart = 1'b0;
   logic [7:0] curX = 8'd0;
   logic [7:0] curY = 8'd0;
   always @(negedge clock) begin
      if (!resetN) begin
         prevStart = 1'b0;
      end else begin
         if (gcdStart && !prevStart) begin
            startRises++;
            checkOutput("issueWhileHeld", resValid, 0);
            checks++;
            assert (issueQ.size() != 0) else begin
               errors++;
               $error("[TB] FAIL unexpectedIssue observed=%0d,%0d expected=none", gcdX, gcdY);
            end
            if (issueQ.size() != 0) begin
               {curX, curY} = issueQ.pop_front();
               checkOutput("issueX", gcdX, curX);
               checkOutput("issueY", gcdY, curY);
            end
         end else if (gcdStart) begin
            checkOutput("stableX", gcdX, curX);
            checkOutput("stableY", gcdY, curY);
         end
         prevStart = gcdStart;
         if (resValid && resReady) begin
            checks++;
            assert (expQ.size() != 0) else begin
               errors++;
               $error("[TB] FAIL unexpectedResult observed=%0d expected=none", resData);
            end
            if (expQ.size() != 0) begin
               checkOutput("result", resData, expQ.pop_front());
            end
         end
      end
   end

   // Queue a pair into the bench model once the DUT has actually accepted it
   function automatic void recordPair(input logic [7:0] x, input logic [7:0] y);
      expQ.push_back(refGcd(x, y));
`ifdef GCD_ZERO_BYPASS_EN
      if (x != 0 && y != 0) issueQ.push_back({x, y});
`else
      issueQ.push_back({x, y});
`endif
   endfunction

   // Offer one pair and hold it until accepted or the cycle budget runs out
   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input int budget);
      int  n = 0;
      bit  accepted = 1'b0;
      @(posedge clock); #1;
      inValid = 1'b1; inX = x; inY = y;
      while (!accepted && n < budget) begin
         @(negedge clock);
         if (inReady) begin
            accepted = 1'b1;
         end else begin
            @(posedge clock); #1;
            n++;
         end
      end
      checkOutput("pushAccepted", accepted, 1);
      if (accepted) recordPair(x, y);
      @(posedge clock); #1;
      inValid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while ((expQ.size() != 0 || busy) && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput("drainDone", (expQ.size() == 0) && !busy, 1);
   endtask

   initial begin
      int rises0;
      int n;
      resetN = 1'b0; inValid = 1'b0; resReady = 1'b0; inX = 8'd0; inY = 8'd0;

      // Reset state
      #3;
      checkOutput("rstInReady", inReady, 1);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstStart", gcdStart, 0);
      checkOutput("rstGcdX", gcdX, 0);
      checkOutput("rstGcdY", gcdY, 0);
      checkOutput("rstResValid", resValid, 0);
      checkOutput("rstResData", resData, 0);
      @(negedge clock); @(negedge clock);
      resetN = 1'b1;

      // Single job and pop-to-start latency
      resReady = 1'b1;
      applyStimulus(8'd10, 8'd5, 10);
      @(negedge clock);
      checkOutput("startBeforePop", gcdStart, 0);
      @(negedge clock);
      checkOutput("startAfterPop", gcdStart, 1);
      checkOutput("latGcdX", gcdX, 10);
      checkOutput("latGcdY", gcdY, 5);
      waitDrain(100);
      checkOutput("idleResValid", resValid, 0);
      checkOutput("idleBusy", busy, 0);

      // Back-to-back jobs come back in order with separate start pulses
      rises0 = startRises;
      applyStimulus(8'd12, 8'd18, 10);
      applyStimulus(8'd7, 8'd3, 10);
      applyStimulus(8'd40, 8'd64, 10);
      waitDrain(300);
      checkOutput("threeStarts", startRises - rises0, 3);

      // Backpressure: first result held, four more fill the FIFO
      resReady = 1'b0;
      applyStimulus(8'd21, 8'd14, 10);
      applyStimulus(8'd15, 8'd25, 10);
      applyStimulus(8'd9, 8'd27, 10);
      applyStimulus(8'd16, 8'd24, 10);
      applyStimulus(8'd35, 8'd49, 10);
      n = 0;
      while (!resValid && n < 100) begin @(negedge clock); n++; end
      checkOutput("heldResValid", resValid, 1);
      checkOutput("fullInReady", inReady, 0);
      checkOutput("fullBusy", busy, 1);

      // Sixth pair is refused while full, including the cycle of the pop that frees a slot
      @(posedge clock); #1;
      inValid = 1'b1; inX = 8'd12; inY = 8'd8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput("sixthRefused", inReady, 0);
         @(posedge clock); #1;
      end
      resReady = 1'b1;
      @(negedge clock);
      checkOutput("pulseInReady", inReady, 0);
      @(posedge clock); #1;
      resReady = 1'b0;
      @(negedge clock);
      checkOutput("popCycleInReady", inReady, 0);
      @(negedge clock);
      checkOutput("afterPopInReady", inReady, 1);
      if (inReady) recordPair(8'd12, 8'd8);
      @(posedge clock); #1;
      inValid = 1'b0;
      resReady = 1'b1;
      waitDrain(600);

      // Reset while the core is working drops everything immediately
      applyStimulus(8'd100, 8'd75, 10);
      applyStimulus(8'd50, 8'd20, 10);
      n = 0;
      while (!gcdStart && n < 20) begin @(negedge clock); n++; end
      checkOutput("startSeen", gcdStart, 1);
      @(negedge clock);
      #2 resetN = 1'b0;
      #1;
      checkOutput("asyncStart", gcdStart, 0);
      checkOutput("asyncResValid", resValid, 0);
      checkOutput("asyncBusy", busy, 0);
      checkOutput("asyncInReady", inReady, 1);
      expQ.delete();
      issueQ.delete();
      @(negedge clock); @(negedge clock);
      resetN = 1'b1;
      applyStimulus(8'd9, 8'd6, 10);
      waitDrain(100);

      // Zero operand: bypassed without a start pulse when enabled, otherwise run on the core
      rises0 = startRises;
      applyStimulus(8'd0, 8'd9, 10);
      applyStimulus(8'd25, 8'd0, 10);
      waitDrain(200);
`ifdef GCD_ZERO_BYPASS_EN
      checkOutput("zeroStarts", startRises - rises0, 0);
`else
      checkOutput("zeroStarts", startRises - rises0, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
